// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl
//   Producer side of the PC register interface in the 16-bit pipelined core.
//   Each cycle it picks the next PC (sequential, redirect, or held) and
//   raises the stall/flush controls from pipeline events:
//   taken-branch redirects, load-use bubbles, instruction-memory waits and
//   halt/resume.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   PC_Out          current PC from the PC register
//   Branch_Taken    EX-stage redirect pulse (taken branch or jump)
//   Branch_Target   redirect address, valid with Branch_Taken
//   Load_Use_Hazard ID-stage load-use detect pulse
//   IMem_Busy       instruction memory not ready (level)
//   Halt            HLT decoded pulse
//   Resume          restart pulse, honoured only while halted
//   PC_In           next PC to the PC register
//   Do_Stall        hold the PC register
//   Flush_IF        clear the IF/ID register
//   Flush_ID        insert a bubble into ID/EX
//   Halted          core halted
//
// All outputs are combinational from the state registers and the current
// inputs; the state registers are updated on the rising clock edge.

module pc_next_ctrl #(
   parameter int PC_WIDTH         = 16,
   parameter int PC_INC           = 1,
   parameter int LOAD_USE_BUBBLES = 1    // legal range 1..3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] PC_Out,
   input  logic                Branch_Taken,
   input  logic [PC_WIDTH-1:0] Branch_Target,
   input  logic                Load_Use_Hazard,
   input  logic                IMem_Busy,
   input  logic                Halt,
   input  logic                Resume,
   output logic [PC_WIDTH-1:0] PC_In,
   output logic                Do_Stall,
   output logic                Flush_IF,
   output logic                Flush_ID,
   output logic                Halted
);

   localparam logic [PC_WIDTH-1:0] INC      = PC_WIDTH'(PC_INC);
   // The hazard cycle itself is the first bubble, so the counter holds
   // only the remaining ones.
   localparam logic [1:0]          BUB_LOAD = 2'(LOAD_USE_BUBBLES - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_MEM = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [1:0]          bub_cnt, bub_cnt_nx;
   logic                pend_valid, pend_valid_nx;
   logic [PC_WIDTH-1:0] pend_target, pend_target_nx;
   logic                halt_req, halt_req_nx;

   logic [PC_WIDTH-1:0] pc_seq;
   logic [PC_WIDTH-1:0] pc_sel;

   assign pc_seq = PC_Out + INC;   // wraps modulo 2^PC_WIDTH

   // ------------------------------------------------------------------
   // Next-state and output decode, first matching rule wins.
   // ------------------------------------------------------------------
   always_comb begin
      state_nx       = state;
      bub_cnt_nx     = bub_cnt;
      pend_valid_nx  = pend_valid;
      pend_target_nx = pend_target;
      halt_req_nx    = halt_req;

      pc_sel   = pc_seq;
      Do_Stall = 1'b0;
      Flush_IF = 1'b0;
      Flush_ID = 1'b0;
      Halted   = 1'b0;

      if (state == HALT) begin
         // Everything except Resume is ignored; the PC stays frozen on
         // the Resume cycle too and restarts the cycle after.
         Do_Stall = 1'b1;
         Halted   = 1'b1;
         if (Resume) begin
            state_nx = RUN;
         end
      end else if (Branch_Taken) begin
         // The redirect kills the younger instructions, so their hazard
         // and halt indications are discarded along with any bubbles.
         Flush_IF    = 1'b1;
         Flush_ID    = 1'b1;
         bub_cnt_nx  = '0;
         halt_req_nx = 1'b0;
         if (IMem_Busy) begin
            Do_Stall       = 1'b1;
            pend_valid_nx  = 1'b1;
            pend_target_nx = Branch_Target;
            state_nx       = WAIT_MEM;
         end else begin
            pc_sel        = Branch_Target;
            pend_valid_nx = 1'b0;
            state_nx      = RUN;
         end
      end else if (IMem_Busy) begin
         // Memory wait: keep bubbling and remember a halt for later.
         Do_Stall = 1'b1;
         state_nx = WAIT_MEM;
         if (Halt) begin
            halt_req_nx = 1'b1;
         end
         if (Load_Use_Hazard) begin
            Flush_ID   = 1'b1;
            bub_cnt_nx = BUB_LOAD;
         end else if (bub_cnt != '0) begin
            Flush_ID   = 1'b1;
            bub_cnt_nx = bub_cnt - 2'd1;
         end
      end else if ((state == WAIT_MEM) && pend_valid) begin
         // Deferred redirect: it supersedes any remaining bubbles.
         pc_sel        = pend_target;
         pend_valid_nx = 1'b0;
         bub_cnt_nx    = '0;
         state_nx      = RUN;
      end else begin
         // RUN, or WAIT_MEM released with nothing pending: the remaining
         // rules are evaluated in the same cycle.
         state_nx = RUN;
         if ((Halt || halt_req) && (bub_cnt == '0) && !Load_Use_Hazard) begin
            Do_Stall    = 1'b1;
            state_nx    = HALT;
            halt_req_nx = 1'b0;
         end else if (Load_Use_Hazard || (bub_cnt != '0)) begin
            Do_Stall = 1'b1;
            Flush_ID = 1'b1;
            if (Load_Use_Hazard) begin
               bub_cnt_nx = BUB_LOAD;
            end else begin
               bub_cnt_nx = bub_cnt - 2'd1;
            end
            if (Halt) begin
               halt_req_nx = 1'b1;
            end
         end
      end

      // A held PC register always sees its own value on PC_In.
      PC_In = Do_Stall ? PC_Out : pc_sel;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         bub_cnt     <= '0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         halt_req    <= 1'b0;
      end else begin
         state       <= state_nx;
         bub_cnt     <= bub_cnt_nx;
         pend_valid  <= pend_valid_nx;
         pend_target <= pend_target_nx;
         halt_req    <= halt_req_nx;
      end
   end

endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Producer side of the PC register interface: generates PC_In and Do_Stall every cycle from the fetched PC (PC_Out) and pipeline events.
- Sequences sequential PC increment, taken-branch redirects, load-use bubbles, instruction-memory wait stalls, and halt/resume.
- Supplies IF/ID and ID/EX flush controls.
- Sits between the EX/hazard logic and the PC register in the 16-bit pipelined core.

Parameters:
PC_WIDTH, 16, width of all PC and target buses
PC_INC, 1, sequential PC increment (word-addressed instruction memory)
LOAD_USE_BUBBLES, 1, bubbles per load-use hazard; legal range 1..3

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
PC_Out  in  PC_WIDTH  current PC from the PC register
Branch_Taken  in  1  EX-stage redirect pulse (branch taken or jump)
Branch_Target  in  PC_WIDTH  redirect address, valid with Branch_Taken
Load_Use_Hazard  in  1  ID-stage load-use detect pulse
IMem_Busy  in  1  instruction memory not ready (level)
Halt  in  1  HLT decoded pulse
Resume  in  1  restart pulse, used only while halted
PC_In  out  PC_WIDTH  next PC to the PC register
Do_Stall  out  1  hold PC register
Flush_IF  out  1  clear IF/ID register
Flush_ID  out  1  insert bubble into ID/EX
Halted  out  1  core halted

Behaviour:
- State registers:
  - FSM: RUN, WAIT_MEM, HALT.
  - Bub_Cnt: 2-bit bubble counter.
  - Pend_Valid / Pend_Target: pending redirect.
  - Halt_Req: latched halt request.
- Reset (async): state=RUN, Bub_Cnt=0, Pend_Valid=0, Pend_Target=0, Halt_Req=0.
- All outputs are combinational from the registers and current inputs. With idle inputs after reset: PC_In=PC_Out+PC_INC, Do_Stall=0, Flush_IF=0, Flush_ID=0, Halted=0.
- Whenever Do_Stall=1, PC_In=PC_Out. Default for all flags is 0.
- Per-cycle priority, first match wins:
  1. HALT state: Do_Stall=1, Halted=1. Branch_Taken, Load_Use_Hazard and Halt are ignored. Resume moves to RUN next cycle; Do_Stall stays 1 on the Resume cycle itself.
  2. Branch_Taken (RUN or WAIT_MEM):
     - Always: Flush_IF=1, Flush_ID=1, Bub_Cnt<=0, Halt_Req<=0. Load_Use_Hazard and Halt in the same cycle are discarded (they belong to younger instructions).
     - If IMem_Busy: Do_Stall=1, Pend_Valid<=1, Pend_Target<=Branch_Target, state<=WAIT_MEM.
     - Else: PC_In=Branch_Target, Do_Stall=0, Pend_Valid<=0, state<=RUN.
     - A newer Branch_Taken overwrites any pending target.
  3. IMem_Busy: Do_Stall=1, state<=WAIT_MEM.
     - Halt sets Halt_Req.
     - Load_Use_Hazard: Flush_ID=1, Bub_Cnt<=LOAD_USE_BUBBLES-1.
     - Bub_Cnt!=0: Flush_ID=1, Bub_Cnt decrements.
  4. WAIT_MEM with IMem_Busy=0 and Pend_Valid=1: PC_In=Pend_Target, Do_Stall=0, Pend_Valid<=0, state<=RUN. Any Bub_Cnt is cleared because the redirect supersedes it.
  5. WAIT_MEM with IMem_Busy=0 and Pend_Valid=0: state<=RUN, then evaluate rules 6-8 in the same cycle.
  6. Halt or Halt_Req, with Bub_Cnt=0 and Load_Use_Hazard=0: Do_Stall=1, state<=HALT, Halt_Req<=0.
  7. Load_Use_Hazard or Bub_Cnt!=0: Do_Stall=1, Flush_ID=1.
     - Load_Use_Hazard loads Bub_Cnt<=LOAD_USE_BUBBLES-1.
     - Otherwise Bub_Cnt decrements.
     - Halt here sets Halt_Req.
  8. Otherwise: PC_In=(PC_Out+PC_INC) mod 2^PC_WIDTH, Do_Stall=0.
- Wrap-around: PC_Out=16'hFFFF with PC_INC=1 gives PC_In=16'h0000, no flag.
- Reset mid-operation: all pending redirect, bubble and halt state is dropped immediately. No output glitch requirement applies during reset.

Test Plan:
- Reset, then idle inputs with PC_Out stepping 0,1,2 -> PC_In=1,2,3 and Do_Stall=0 every cycle; PC_Out=16'hFFFF -> PC_In=16'h0000.
- Branch_Taken=1, Branch_Target=16'h0040, IMem_Busy=0 at PC_Out=16'h0010 -> same cycle PC_In=16'h0040, Do_Stall=0, Flush_IF=1, Flush_ID=1; a simultaneous Load_Use_Hazard produces no bubble.
- Load_Use_Hazard pulse at PC_Out=16'h0005, LOAD_USE_BUBBLES=2 -> Do_Stall=1 and Flush_ID=1 for exactly 2 cycles, then PC_In=16'h0006.
- IMem_Busy high 3 cycles with Branch_Taken (target 16'h0100) on busy cycle 1 -> Do_Stall=1 for 3 cycles; first non-busy cycle PC_In=16'h0100, Do_Stall=0; Flush_IF=1 only on the branch cycle.
- Halt pulse at PC_Out=16'h0020 -> Halted=1 from next cycle, Do_Stall=1, Branch_Taken ignored; Resume -> Halted=0 next cycle, then PC_In=16'h0021.
- Assert reset while WAIT_MEM with Pend_Valid=1 -> after deassert with IMem_Busy=0, PC_In=PC_Out+1 (pending target discarded), Halted=0.
